emergency_request_arbiter: RTL and testbench
============================================

Name: emergency_request_arbiter

Overview:
Conditions the raw emergency-vehicle detector inputs (NS and EW) and produces the clean, mutually exclusive emergency_ns / emergency_ew requests consumed by the traffic light controller. It sits directly upstream of the controller. It synchronises and debounces each detector, arbitrates simultaneous requests round-robin, and enforces a minimum hold and an all-clear gap between grants. The two outputs are never high together and never switch directly from one to the other.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw input (>=2)
DEBOUNCE, 4, consecutive stable cycles required to change a filtered level (>=1)
MIN_HOLD, 8, minimum cycles a grant stays asserted (>=1)
CLEAR_CYCLES, 3, cycles with both outputs low between any two grants (>=1)
MAX_HOLD, 64, grant timeout in cycles (> MIN_HOLD; used only with EMERG_LOCKOUT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
raw_emerg_ns  input  1  asynchronous NS detector level
raw_emerg_ew  input  1  asynchronous EW detector level
emergency_ns  output  1  registered NS emergency request to controller
emergency_ew  output  1  registered EW emergency request to controller
busy  output  1  high whenever FSM is not IDLE
timeout_pulse  output  1  one-cycle pulse on grant timeout (constant 0 without macro)

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All flops update on posedge clk.
- Reset, sampled at a posedge (including mid-grant), has the following effect at that edge:
  - emergency_ns, emergency_ew, busy, timeout_pulse = 0.
  - Synchroniser flops, filtered levels and all counters = 0.
  - State = IDLE; last_served = EW, so NS wins the first tie.
  - Lockout flags cleared.
- Synchroniser: SYNC_STAGES-deep flop chain per input.
- Debounce, per channel:
  - Counter cleared whenever the synced value equals the filtered value.
  - Otherwise the counter increments. When it reaches DEBOUNCE-1, the filtered value flips and the counter clears.
  - Pulses shorter than DEBOUNCE cycles never reach the filtered level.
- FSM states: IDLE, GRANT_NS, GRANT_EW, CLEAR. Outputs are registered alongside the state:
  - emergency_ns = 1 exactly while state is GRANT_NS.
  - emergency_ew = 1 exactly while state is GRANT_EW.
- IDLE transitions:
  - Only filt_ns set -> GRANT_NS.
  - Only filt_ew set -> GRANT_EW.
  - Both set -> grant the channel opposite to last_served.
  - On any grant: hold_cnt = 0 and last_served updated.
  - Neither set -> stay in IDLE.
  - A locked-out channel is treated as not requesting.
- GRANT_x:
  - hold_cnt increments and saturates.
  - Move to CLEAR when filt_x = 0 and hold_cnt >= MIN_HOLD-1. The grant therefore lasts >= MIN_HOLD cycles even for a short filtered request.
  - A request on the other channel during the grant is not acted on; it is re-evaluated in IDLE after CLEAR.
- CLEAR: both outputs 0 for exactly CLEAR_CYCLES cycles, then IDLE. Gap between grants is >= CLEAR_CYCLES+1 cycles.
- Latency: from a raw edge held stable, the output asserts SYNC_STAGES+DEBOUNCE+1 edges later when the FSM is IDLE (7 with defaults).
- Counter widths: $clog2(max value)+1 bits. No wrap: the counter saturates.

Optional Feature:
Macro EMERG_LOCKOUT_EN.
- Defined:
  - In GRANT_x, when hold_cnt reaches MAX_HOLD-1, go to CLEAR regardless of filt_x.
  - Pulse timeout_pulse for one cycle in the same cycle the output drops.
  - Set lockout_x. lockout_x clears only when filt_x returns to 0, so a stuck detector cannot monopolise the junction.
- Not defined:
  - No MAX_HOLD logic and no lockout flags.
  - Grant persists while filt_x is high; timeout_pulse is tied to 0.

Decomposition:
- Package emerg_pkg holds:
  - FSM state localparams (2-bit: IDLE=0, GRANT_NS=1, GRANT_EW=2, CLEAR=3).
  - Channel index constants (CH_NS=0, CH_EW=1).
  - Default timing constants.
- Sub-module emerg_input_filter (synchroniser plus debounce, parameters SYNC_STAGES and DEBOUNCE) is instantiated once per channel.
- Arbitration FSM lives in the top module.

Test Plan:
- Glitch rejection: raw_emerg_ns high for 3 cycles, then low -> emergency_ns never asserts; busy stays 0.
- Latency and min hold: raw_emerg_ns high for 6 cycles -> emergency_ns rises 7 edges after the raw rise and stays high exactly 8 cycles; then 3 cycles of CLEAR; busy falls afterwards.
- Simultaneous requests after reset: both raw inputs rise in the same cycle -> emergency_ns granted first. Drop raw_ns after 20 cycles -> emergency_ns falls, both outputs low for 3 cycles, then emergency_ew rises. Never both high.
- Round-robin: following that EW grant, release and re-request both together -> NS is granted.
- Reset mid-grant: assert reset for 1 cycle while emergency_ew=1 -> all outputs 0 at that edge. With raw inputs still high, a re-grant (NS first) occurs 7 edges after reset deasserts.
- With EMERG_LOCKOUT_EN: hold raw_emerg_ns high for 200 cycles -> emergency_ns drops after 64 cycles with a coincident single timeout_pulse, and is not re-granted until raw_emerg_ns falls and rises again.

Source files
------------

// File: rtl/emerg_pkg.sv
// emerg_pkg: FSM state codes, channel indices and default timing constants for the emergency request arbiter
package emerg_pkg;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_NS = 2'd1;
  localparam logic [1:0] GRANT_EW = 2'd2;
  localparam logic [1:0] CLEAR    = 2'd3;
  localparam int CH_NS = 0;
  localparam int CH_EW = 1;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_MIN_HOLD     = 8;
  localparam int DEF_CLEAR_CYCLES = 3;
  localparam int DEF_MAX_HOLD     = 64;
endpackage

// File: rtl/emerg_input_filter.sv
// emerg_input_filter: SYNC_STAGES-deep synchroniser plus DEBOUNCE-cycle level filter; ports clk, reset, raw in, filt out
module emerg_input_filter
  import emerg_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(DEBOUNCE - 1) + 1;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d;
  logic synced, flip;
  assign synced = sync_q[SYNC_STAGES-1];
  assign filt = filt_q;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    flip   = (synced != filt_q) && (cnt_q == CW'(DEBOUNCE - 1));
    filt_d = flip ? ~filt_q : filt_q;
    cnt_d  = (synced == filt_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
endmodule

// File: rtl/emergency_request_arbiter.sv
// emergency_request_arbiter: filters NS/EW detectors and issues exclusive round-robin grants with min hold and clear gap; in clk, reset, raw_emerg_ns, raw_emerg_ew; out emergency_ns, emergency_ew, busy, timeout_pulse; EMERG_LOCKOUT_EN adds MAX_HOLD timeout with per-channel lockout
module emergency_request_arbiter
  import emerg_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int MIN_HOLD     = DEF_MIN_HOLD,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int MAX_HOLD     = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_emerg_ns,
  input  logic raw_emerg_ew,
  output logic emergency_ns,
  output logic emergency_ew,
  output logic busy,
  output logic timeout_pulse
);
  localparam int HW = $clog2(MAX_HOLD - 1) + 1;
  localparam int CW = $clog2(CLEAR_CYCLES - 1) + 1;
`ifdef EMERG_LOCKOUT_EN
  localparam int HOLD_SAT = MAX_HOLD - 1;
`else
  localparam int HOLD_SAT = MIN_HOLD - 1;
`endif
  logic filt_ns, filt_ew, req_ns, req_ew;
  logic [1:0] state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] clr_q, clr_d;
  logic last_q, last_d;
  logic emergency_ns_q, emergency_ns_d;
  logic emergency_ew_q, emergency_ew_d;
  logic busy_q, busy_d;
  emerg_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_filt_ns (
    .clk(clk), .reset(reset), .raw(raw_emerg_ns), .filt(filt_ns)
  );
  emerg_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_filt_ew (
    .clk(clk), .reset(reset), .raw(raw_emerg_ew), .filt(filt_ew)
  );
  assign emergency_ns = emergency_ns_q;
  assign emergency_ew = emergency_ew_q;
  assign busy         = busy_q;
`ifdef EMERG_LOCKOUT_EN
  logic lock_ns_q, lock_ns_d, lock_ew_q, lock_ew_d;
  logic tmo, timeout_q, timeout_d;
  assign req_ns        = filt_ns & ~lock_ns_q;
  assign req_ew        = filt_ew & ~lock_ew_q;
  assign timeout_pulse = timeout_q;
`else
  assign req_ns        = filt_ns;
  assign req_ew        = filt_ew;
  assign timeout_pulse = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      clr_q          <= '0;
      last_q         <= 1'(CH_EW);
      emergency_ns_q <= 1'b0;
      emergency_ew_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef EMERG_LOCKOUT_EN
      lock_ns_q      <= 1'b0;
      lock_ew_q      <= 1'b0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      clr_q          <= clr_d;
      last_q         <= last_d;
      emergency_ns_q <= emergency_ns_d;
      emergency_ew_q <= emergency_ew_d;
      busy_q         <= busy_d;
`ifdef EMERG_LOCKOUT_EN
      lock_ns_q      <= lock_ns_d;
      lock_ew_q      <= lock_ew_d;
      timeout_q      <= timeout_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d  = (hold_q == HW'(HOLD_SAT)) ? hold_q : hold_q + 1'b1;
    clr_d   = '0;
    last_d  = last_q;
`ifdef EMERG_LOCKOUT_EN
    tmo     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_ns && (!req_ew || last_q == 1'(CH_EW))) begin
          state_d = GRANT_NS;
          last_d  = 1'(CH_NS);
          hold_d  = '0;
        end else if (req_ew) begin
          state_d = GRANT_EW;
          last_d  = 1'(CH_EW);
          hold_d  = '0;
        end
      end
      GRANT_NS: begin
        if (!filt_ns && hold_q >= HW'(MIN_HOLD - 1)) state_d = CLEAR;
`ifdef EMERG_LOCKOUT_EN
        else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = CLEAR;
          tmo     = 1'b1;
        end
`endif
      end
      GRANT_EW: begin
        if (!filt_ew && hold_q >= HW'(MIN_HOLD - 1)) state_d = CLEAR;
`ifdef EMERG_LOCKOUT_EN
        else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = CLEAR;
          tmo     = 1'b1;
        end
`endif
      end
      CLEAR: begin
        state_d = (clr_q == CW'(CLEAR_CYCLES - 1)) ? IDLE : CLEAR;
        clr_d   = (clr_q == CW'(CLEAR_CYCLES - 1)) ? '0 : clr_q + 1'b1;
      end
    endcase
`ifdef EMERG_LOCKOUT_EN
    lock_ns_d = (tmo && state_q == GRANT_NS) | (lock_ns_q & filt_ns);
    lock_ew_d = (tmo && state_q == GRANT_EW) | (lock_ew_q & filt_ew);
`endif
  end
  always_comb begin
    emergency_ns_d = state_d == GRANT_NS;
    emergency_ew_d = state_d == GRANT_EW;
    busy_d         = state_d != IDLE;
`ifdef EMERG_LOCKOUT_EN
    timeout_d      = tmo;
`endif
  end
endmodule

// File: tb/tb_emergency_request_arbiter.sv
// tb_emergency_request_arbiter: directed and random checks of the arbiter against a history-based reference model
module tb_emergency_request_arbiter;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int MINH = 8;
  localparam int CLR  = 3;
  localparam int MAXH = 64;
  localparam int NH   = SYNC + DEB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_ns = 1'b0;
  logic raw_ew = 1'b0;
  logic emergency_ns, emergency_ew, busy, timeout_pulse;
  int compared = 0;
  int mismatched = 0;
  int edge_no = 0;
  int rise_ns = 0, fall_ns = 0, rise_ew = 0, fall_ew = 0, busy_fall = 0;
  int ns_rises = 0, to_cnt = 0, to_edge = 0;
  bit seen_busy = 0, seen_both = 0;
  bit p_ns = 0, p_ew = 0, p_busy = 0;
  bit hist [2][NH];
  bit filt [2];
  bit lock [2];
  int owner = -1, gap = 0, held = 0, last = 1;
  bit m_to = 0;
  emergency_request_arbiter #(
    .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .MIN_HOLD(MINH), .CLEAR_CYCLES(CLR), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk), .reset(reset), .raw_emerg_ns(raw_ns), .raw_emerg_ew(raw_ew),
    .emergency_ns(emergency_ns), .emergency_ew(emergency_ew), .busy(busy), .timeout_pulse(timeout_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model(input bit a, input bit b, input bit r);
    bit req [2];
    bit diff;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < NH; i++) hist[c][i] = 0;
        filt[c] = 0;
        lock[c] = 0;
      end
      owner = -1; gap = 0; held = 0; last = 1; m_to = 0;
    end else begin
      for (int c = 0; c < 2; c++)
        for (int i = NH - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[0][0] = a;
      hist[1][0] = b;
      m_to = 0;
      for (int c = 0; c < 2; c++) begin
        req[c] = filt[c] && !lock[c];
        if (!filt[c]) lock[c] = 0;
      end
      if (owner >= 0) begin
        held++;
        if (!filt[owner] && held >= MINH) begin
          owner = -1; gap = CLR;
        end
`ifdef EMERG_LOCKOUT_EN
        else if (held >= MAXH) begin
          lock[owner] = 1; m_to = 1; owner = -1; gap = CLR;
        end
`endif
      end else if (gap > 0) begin
        gap--;
      end else if (req[0] || req[1]) begin
        owner = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
        last = owner;
        held = 0;
      end
      for (int c = 0; c < 2; c++) begin
        diff = 1;
        for (int i = 0; i < DEB; i++) if (hist[c][SYNC+i] == filt[c]) diff = 0;
        if (diff) filt[c] = !filt[c];
      end
    end
  endtask
  task automatic step(input bit a, input bit b, input bit r);
    @(negedge clk);
    raw_ns = a;
    raw_ew = b;
    reset = r;
    @(posedge clk);
    edge_no++;
    model(a, b, r);
    #1;
    chk("model_ns", emergency_ns, owner == 0);
    chk("model_ew", emergency_ew, owner == 1);
    chk("model_busy", busy, owner >= 0 || gap > 0);
    chk("model_timeout", timeout_pulse, m_to);
    if (emergency_ns && emergency_ew) seen_both = 1;
    if (busy) seen_busy = 1;
    if (emergency_ns && !p_ns) begin rise_ns = edge_no; ns_rises++; end
    if (!emergency_ns && p_ns) fall_ns = edge_no;
    if (emergency_ew && !p_ew) rise_ew = edge_no;
    if (!emergency_ew && p_ew) fall_ew = edge_no;
    if (!busy && p_busy) busy_fall = edge_no;
    if (timeout_pulse) begin to_cnt++; to_edge = edge_no; end
    p_ns = emergency_ns;
    p_ew = emergency_ew;
    p_busy = busy;
  endtask
  initial begin
    int t0, rst_edge, rate;
    bit ra, rb;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("reset_ns", emergency_ns, 0);
    chk("reset_ew", emergency_ew, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout_pulse, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    seen_busy = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("glitch_busy", seen_busy, 0);
    chk("glitch_ns_rises", ns_rises, 0);
    t0 = edge_no + 1;
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    chk("latency_ns", rise_ns - t0 + 1, 7);
    chk("min_hold_ns", fall_ns - rise_ns, MINH);
    chk("clear_busy_fall", busy_fall - fall_ns, CLR);
    step(0, 0, 1);
    step(0, 0, 0);
    t0 = edge_no + 1;
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0);
    chk("tie_latency_ns", rise_ns - t0 + 1, 7);
    chk("tie_ns_first", rise_ns < rise_ew, 1);
    chk("tie_gap", rise_ew - fall_ns, CLR + 1);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    t0 = edge_no + 1;
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    chk("rr_latency_ns", rise_ns - t0 + 1, 7);
    chk("rr_ns_held", emergency_ns, 1);
    chk("rr_ew_idle", emergency_ew, 0);
    for (int i = 0; i < 80 && !emergency_ew; i++) step(0, 1, 0);
    chk("mid_ew_granted", emergency_ew, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    rst_edge = edge_no;
    chk("mid_reset_ew", emergency_ew, 0);
    chk("mid_reset_busy", busy, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    chk("regrant_latency", rise_ns - rst_edge, 7);
    chk("regrant_ew_low", emergency_ew, 0);
    step(0, 0, 1);
    ns_rises = 0;
    to_cnt = 0;
    for (int i = 0; i < 200; i++) step(1, 0, 0);
`ifdef EMERG_LOCKOUT_EN
    chk("lockout_hold", fall_ns - rise_ns, MAXH);
    chk("lockout_pulses", to_cnt, 1);
    chk("lockout_pulse_edge", to_edge, fall_ns);
    chk("lockout_no_regrant", ns_rises, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    chk("lockout_release", ns_rises, 2);
`else
    chk("stuck_ns_held", emergency_ns, 1);
    chk("stuck_no_timeout", to_cnt, 0);
    chk("stuck_single_grant", ns_rises, 1);
`endif
    step(0, 0, 1);
    ra = 0;
    rb = 0;
    for (int blk = 0; blk < 15; blk++) begin
      rate = ($urandom_range(0, 2) == 0) ? 3 : (($urandom_range(0, 1) == 0) ? 12 : 90);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, rate) == 0) ra = !ra;
        if ($urandom_range(0, rate) == 0) rb = !rb;
        step(ra, rb, $urandom_range(0, 599) == 0);
      end
    end
    chk("never_both", seen_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
